// File: rtl/psm_pkg.sv
// psm_pkg -- shared constants for the pulse-skipping modulator.
//   STATE_W        : width of the scheduler state code
//   SKIPPED_CNT_W  : width of the optional skipped-period counter
//   ST_IDLE/ST_PASS/ST_SKIP : scheduler state encoding
package psm_pkg;

  localparam int STATE_W       = 2;
  localparam int SKIPPED_CNT_W = 16;

  localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
  localparam logic [STATE_W-1:0] ST_PASS = 2'd1;
  localparam logic [STATE_W-1:0] ST_SKIP = 2'd2;

endpackage

// File: rtl/psm_period_cnt.sv
// psm_period_cnt -- period counter, boundary flag and duty compare.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   run       : scheduler is in PASS or SKIP; counter is held at 0 otherwise
//   duty      : active duty value (unsigned)
//   cnt       : current position within the period
//   boundary  : last cycle of the period (cnt at its maximum)
//   pwm_raw   : unmasked PWM level, cnt < duty
module psm_period_cnt #(
  parameter int RESOLUTION = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  input  logic [RESOLUTION-1:0] duty,
  output logic [RESOLUTION-1:0] cnt,
  output logic                  boundary,
  output logic                  pwm_raw
);

  localparam logic [RESOLUTION-1:0] CNT_MAX = '1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      cnt <= '0;
    else if (run) cnt <= cnt + RESOLUTION'(1);
    else          cnt <= '0;
  end

  assign boundary = run && (cnt == CNT_MAX);
  assign pwm_raw  = (cnt < duty);

endmodule

// File: rtl/psm_scheduler.sv
// psm_scheduler -- pulse-skipping PWM scheduler: passes one PWM period, then
// skips skip_act periods, repeating while en is held.
// Optional build macro: PSM_SKIP_CNT_EN adds the skipped_cnt status output.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   en            : run request, honoured in IDLE and at period boundaries
//   cfg_valid/ready, cfg_duty, cfg_skip : configuration handshake
//   psm_out       : registered pulse-skipped PWM output
//   period_start  : registered pulse on the first cycle of each active period
//   skipped_cnt   : (PSM_SKIP_CNT_EN only) saturating count of skipped periods
//   state         : current scheduler state
module psm_scheduler import psm_pkg::*; #(
  parameter int RESOLUTION = 8,
  parameter int SKIP_WIDTH = 4,
  parameter int DUTY       = 128,
  parameter int SKIP       = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic [RESOLUTION-1:0]    cfg_duty,
  input  logic [SKIP_WIDTH-1:0]    cfg_skip,
  output logic                     psm_out,
  output logic                     period_start,
`ifdef PSM_SKIP_CNT_EN
  output logic [SKIPPED_CNT_W-1:0] skipped_cnt,
`endif
  output logic [STATE_W-1:0]       state
);

  localparam logic [RESOLUTION-1:0] DUTY_INIT = RESOLUTION'(DUTY);
  localparam logic [SKIP_WIDTH-1:0] SKIP_INIT = SKIP_WIDTH'(SKIP);

  logic [STATE_W-1:0]    state_q, state_d;
  logic [SKIP_WIDTH-1:0] skip_rem, skip_rem_d;
  logic [RESOLUTION-1:0] duty_act;
  logic [SKIP_WIDTH-1:0] skip_act, skip_eff;
  logic [RESOLUTION-1:0] cnt;
  logic                  boundary, pwm_raw, cfg_accept;
  logic                  psm_out_p1, period_start_p1;

  psm_period_cnt #(.RESOLUTION(RESOLUTION)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .run      (state_q != ST_IDLE),
    .duty     (duty_act),
    .cnt      (cnt),
    .boundary (boundary),
    .pwm_raw  (pwm_raw)
  );

  assign cfg_ready  = (state_q == ST_IDLE) || boundary;
  assign cfg_accept = cfg_valid && cfg_ready;
  // A skip count accepted on the boundary already steers this edge's decision.
  assign skip_eff   = cfg_accept ? cfg_skip : skip_act;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      duty_act <= DUTY_INIT;
      skip_act <= SKIP_INIT;
    end else if (cfg_accept) begin
      duty_act <= cfg_duty;
      skip_act <= cfg_skip;
    end
  end

  always_comb begin
    state_d    = state_q;
    skip_rem_d = skip_rem;
    case (state_q)
      ST_IDLE: if (en) state_d = ST_PASS;
      ST_PASS: begin
        if (boundary) begin
          if (!en)                 state_d = ST_IDLE;
          else if (skip_eff == '0) state_d = ST_PASS;
          else begin
            state_d    = ST_SKIP;
            skip_rem_d = skip_eff;
          end
        end
      end
      ST_SKIP: begin
        if (boundary) begin
          if (!en)                                state_d = ST_IDLE;
          else if (skip_rem == SKIP_WIDTH'(1))    state_d = ST_PASS;
          else                                    skip_rem_d = skip_rem - SKIP_WIDTH'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      skip_rem <= '0;
    end else begin
      state_q  <= state_d;
      skip_rem <= skip_rem_d;
    end
  end

  // ---- stage p1: registered outputs, one clock after the producing cnt ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      psm_out_p1      <= 1'b0;
      period_start_p1 <= 1'b0;
    end else begin
      psm_out_p1      <= pwm_raw && (state_q == ST_PASS);
      period_start_p1 <= (cnt == '0) && (state_q != ST_IDLE);
    end
  end

  assign psm_out      = psm_out_p1;
  assign period_start = period_start_p1;
  assign state        = state_q;

`ifdef PSM_SKIP_CNT_EN
  function automatic logic [SKIPPED_CNT_W-1:0] sat_inc(input logic [SKIPPED_CNT_W-1:0] v);
    return (v == '1) ? v : v + SKIPPED_CNT_W'(1);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                skipped_cnt <= '0;
    else if (state_q == ST_SKIP && boundary) skipped_cnt <= sat_inc(skipped_cnt);
  end
`endif

endmodule

// File: tb/tb_psm_scheduler.sv
// tb_psm_scheduler -- self-checking bench for psm_scheduler at RESOLUTION=4,
// SKIP_WIDTH=4 (16-clock periods), reset duty 10, reset skip 1.
module tb_psm_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [3:0] cfg_duty = 4'd0;
  logic [3:0] cfg_skip = 4'd0;
  logic       psm_out;
  logic       period_start;
  logic [1:0] state;
`ifdef PSM_SKIP_CNT_EN
  logic [15:0] skipped_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  psm_scheduler #(.RESOLUTION(4), .SKIP_WIDTH(4), .DUTY(10), .SKIP(1)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_duty     (cfg_duty),
    .cfg_skip     (cfg_skip),
    .psm_out      (psm_out),
    .period_start (period_start),
`ifdef PSM_SKIP_CNT_EN
    .skipped_cnt  (skipped_cnt),
`endif
    .state        (state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] duty;
    logic [3:0] skip;
    logic [5:0] mask;   // bit p set: period p is a passed period
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    en = 1'b0;
    cfg_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Offer a config in IDLE with en=1; returns right after the entry edge.
  task automatic start_run(input logic [3:0] d, input logic [3:0] s);
    cfg_valid = 1'b1;
    cfg_duty  = d;
    cfg_skip  = s;
    en        = 1'b1;
    tick();
    cfg_valid = 1'b0;
  endtask

  initial begin
    int hi, ps, ps_first, st, cnt_bad;
    int hi0, hi1, hi2;

    vecs[0] = '{duty: 4'd8,  skip: 4'd2, mask: 6'b001001};
    vecs[1] = '{duty: 4'd15, skip: 4'd0, mask: 6'b111111};
    vecs[2] = '{duty: 4'd3,  skip: 4'd1, mask: 6'b010101};
    vecs[3] = '{duty: 4'd0,  skip: 4'd0, mask: 6'b111111};
    vecs[4] = '{duty: 4'd15, skip: 4'd5, mask: 6'b000001};
    vecs[5] = '{duty: 4'd1,  skip: 4'd4, mask: 6'b100001};

    // Reset values, during and after reset
    rst = 1'b1;
    #1;
    chk("rst_state", state, 0);
    chk("rst_psm_out", psm_out, 0);
    chk("rst_period_start", period_start, 0);
    chk("rst_cfg_ready", cfg_ready, 1);
    tick();
    rst = 1'b0;
    tick();
    chk("idle_state", state, 0);
    chk("idle_cfg_ready", cfg_ready, 1);
`ifdef PSM_SKIP_CNT_EN
    chk("rst_skipped_cnt", skipped_cnt, 0);
`endif

    // Table-driven steady runs: per period high count, state, period_start
    for (int v = 0; v < 6; v++) begin
      do_reset();
      start_run(vecs[v].duty, vecs[v].skip);
      for (int p = 0; p < 6; p++) begin
        hi = 0; ps = 0; ps_first = 0; st = 0;
        for (int k = 1; k <= 16; k++) begin
          tick();
          if (k == 1) begin
            st = state;
            ps_first = period_start;
          end
          hi += psm_out;
          ps += period_start;
        end
        chk($sformatf("v%0d_p%0d_high", v, p), hi, vecs[v].mask[p] ? vecs[v].duty : 0);
        chk($sformatf("v%0d_p%0d_state", v, p), st, vecs[v].mask[p] ? 1 : 2);
        chk($sformatf("v%0d_p%0d_pstart_first", v, p), ps_first, 1);
        chk($sformatf("v%0d_p%0d_pstart_count", v, p), ps, 1);
      end
    end

    // Config handshake raised mid-period, then graceful stop
    do_reset();
    start_run(4'd8, 4'd0);
    hi0 = 0; hi1 = 0; hi2 = 0; cnt_bad = 0;
    for (int j = 1; j <= 48; j++) begin
      tick();
      if (j <= 16)      hi0 += psm_out;
      else if (j <= 32) hi1 += psm_out;
      else              hi2 += psm_out;
      if (j <= 14 && cfg_ready) cnt_bad++;
      if (j == 15) chk("hs_ready_at_boundary", cfg_ready, 1);
      if (j == 16) chk("hs_ready_after_accept", cfg_ready, 0);
      if (j == 5) begin
        cfg_valid = 1'b1;
        cfg_duty  = 4'd4;
        cfg_skip  = 4'd0;
      end
      if (j == 16) cfg_valid = 1'b0;
      if (j == 35) en = 1'b0;
      if (j >= 35 && j <= 47 && state != 2'd1) cnt_bad += 100;
    end
    chk("hs_ready_low_and_stop_pass_cycles", cnt_bad, 0);
    chk("hs_period0_high", hi0, 8);
    chk("hs_period1_high", hi1, 4);
    chk("stop_period2_high", hi2, 4);
    chk("stop_state_idle", state, 0);
    hi = 0; ps = 0;
    for (int j = 0; j < 10; j++) begin
      tick();
      hi += psm_out;
      ps += period_start;
    end
    chk("stop_psm_out_quiet", hi, 0);
    chk("stop_pstart_quiet", ps, 0);
    chk("stop_cfg_ready", cfg_ready, 1);
    chk("stop_state_stays_idle", state, 0);

    // Reset mid-run at cnt=6, then restart with reset duty
    do_reset();
    start_run(4'd8, 4'd0);
    for (int j = 1; j <= 6; j++) tick();
    chk("mid_psm_out_before_rst", psm_out, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_psm_out", psm_out, 0);
    chk("mid_rst_state", state, 0);
    chk("mid_rst_cfg_ready", cfg_ready, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    hi = 0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      hi += psm_out;
    end
    chk("mid_restart_duty_high", hi, 10);
    tick();
    chk("mid_restart_reset_skip_state", state, 2);

`ifdef PSM_SKIP_CNT_EN
    // skip=3: 8 passed periods span 29 periods with 7 gaps of 3
    do_reset();
    start_run(4'd8, 4'd3);
    for (int j = 0; j < 29 * 16; j++) tick();
    chk("skipped_cnt_8th_pass", skipped_cnt, 21);
    chk("skipped_cnt_state_skip", state, 2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
